// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, frame totals and the update FSM state encoding
// for the frame scheduler and its axis counters.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    UPD_IDLE = 2'd0,
    UPD_REQ  = 2'd1,
    UPD_DONE = 2'd2
  } update_state_e;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input logic [COUNT_W-1:0] v,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync decode.
// The next-state count is exported so the parent can register aligned decodes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] count_next,
  output logic               at_last,
  output logic               visible_next,
  output logic               sync_n
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] VIS_END  = COUNT_W'(VISIBLE);
  localparam logic [COUNT_W-1:0] SYNC_BEG = COUNT_W'(VISIBLE + FRONT);
  localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(VISIBLE + FRONT + SYNC);

  always_comb begin
    at_last    = (count == LAST);
    count_next = count;
    if (advance) begin
      count_next = at_last ? '0 : count + COUNT_W'(1);
    end
    visible_next = (count_next < VIS_END);
  end

  // Sync is decoded from count_next so it lines up with the count it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      sync_n <= 1'b1;
    end else begin
      count  <= count_next;
      sync_n <= !in_window(count_next, SYNC_BEG, SYNC_END);
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA raster timing plus a once-per-frame game update window opened at the
// first blanking line, with a saturating count of frames whose update was missed.
module vga_frame_scheduler
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               CLK_25MHZ,
  input  logic               RESET_N,
  input  logic               UPDATE_ACK,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic               VIDEO_ON,
  output logic [COUNT_W-1:0] PIX_X,
  output logic [COUNT_W-1:0] PIX_Y,
  output logic               FRAME_START,
  output logic               UPDATE_REQ,
  output logic [7:0]         OVERRUN_CNT,
  output update_state_e      FSM_STATE
);

  localparam logic [COUNT_W-1:0] REQ_LINE = COUNT_W'(V_VISIBLE);

  logic [COUNT_W-1:0] x_next;
  logic [COUNT_W-1:0] y_next;
  logic               x_last;
  logic               y_last;
  logic               x_vis_next;
  logic               y_vis_next;
  logic               frame_end;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk          (CLK_25MHZ),
    .rst_n        (RESET_N),
    .advance      (1'b1),
    .count        (PIX_X),
    .count_next   (x_next),
    .at_last      (x_last),
    .visible_next (x_vis_next),
    .sync_n       (VGA_HSYNC)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk          (CLK_25MHZ),
    .rst_n        (RESET_N),
    .advance      (x_last),
    .count        (PIX_Y),
    .count_next   (y_next),
    .at_last      (y_last),
    .visible_next (y_vis_next),
    .sync_n       (VGA_VSYNC)
  );

  assign frame_end = x_last && y_last;

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      VIDEO_ON    <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      VIDEO_ON    <= x_vis_next && y_vis_next;
      FRAME_START <= (x_next == '0) && (y_next == '0);
    end
  end

  // Handshake: UPDATE_REQ is high from the (0,V_VISIBLE) cycle while in REQ;
  // the edge that samples UPDATE_ACK=1 in REQ closes it. ACK outside REQ is
  // ignored, and a REQ still open on the frame's last cycle without ACK counts
  // one overrun.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      FSM_STATE   <= UPD_IDLE;
      UPDATE_REQ  <= 1'b0;
      OVERRUN_CNT <= 8'd0;
    end else begin
      case (FSM_STATE)
        UPD_IDLE: begin
          if ((x_next == '0) && (y_next == REQ_LINE)) begin
            FSM_STATE  <= UPD_REQ;
            UPDATE_REQ <= 1'b1;
          end
        end
        UPD_REQ: begin
          if (frame_end) begin
            FSM_STATE  <= UPD_IDLE;
            UPDATE_REQ <= 1'b0;
            if (!UPDATE_ACK && (OVERRUN_CNT != 8'hFF)) begin
              OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
            end
          end else if (UPDATE_ACK) begin
            FSM_STATE  <= UPD_DONE;
            UPDATE_REQ <= 1'b0;
          end
        end
        UPD_DONE: begin
          if (frame_end) begin
            FSM_STATE <= UPD_IDLE;
          end
        end
        default: begin
          FSM_STATE  <= UPD_IDLE;
          UPDATE_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler on a shrunken raster (12 x 9) so that
// multi-hundred-frame scenarios stay short; expected values are hand-derived.
module tb_vga_frame_scheduler;
  import vga_timing_pkg::*;

  // Raster: H 6+1+3+2 = 12 clocks, V 5+1+2+1 = 9 lines, 108 clocks per frame.
  // HSYNC low for x 7..9, VSYNC low for y 6..7, update window opens at (0,5).
  localparam int H_LAST = 11;
  localparam int V_LAST = 8;
  localparam int FRAME  = 108;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ack = 1'b0;
  logic          vga_hsync;
  logic          vga_vsync;
  logic          video_on;
  logic [9:0]    pix_x;
  logic [9:0]    pix_y;
  logic          frame_start;
  logic          update_req;
  logic [7:0]    overrun_cnt;
  update_state_e fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int mx = 0;
  int my = 0;
  int hi, cyc, vis, hs_low, vs_low;

  vga_frame_scheduler #(
    .H_VISIBLE (6), .H_FRONT (1), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) dut (
    .CLK_25MHZ   (clk),
    .RESET_N     (rst_n),
    .UPDATE_ACK  (ack),
    .VGA_HSYNC   (vga_hsync),
    .VGA_VSYNC   (vga_vsync),
    .VIDEO_ON    (video_on),
    .PIX_X       (pix_x),
    .PIX_Y       (pix_y),
    .FRAME_START (frame_start),
    .UPDATE_REQ  (update_req),
    .OVERRUN_CNT (overrun_cnt),
    .FSM_STATE   (fsm_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: one clock, then sample 1ns after the edge; the raster model follows.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (mx == H_LAST) begin
        mx = 0;
        my = (my == V_LAST) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic run_to(input int x, input int y);
    for (int g = 0; g < 300 && !(mx == x && my == y); g++) step();
  endtask

  task automatic wait_req_rise(input string tag);
    for (int g = 0; g < 300 && !update_req; g++) step();
    check({tag, "_req"}, update_req, 1);
    check({tag, "_req_x"}, pix_x, 0);
    check({tag, "_req_y"}, pix_y, 5);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, pix_x, 0);
    check({tag, "_y"}, pix_y, 0);
    check({tag, "_hsync"}, vga_hsync, 1);
    check({tag, "_vsync"}, vga_vsync, 1);
    check({tag, "_video"}, video_on, 0);
    check({tag, "_fstart"}, frame_start, 0);
    check({tag, "_req"}, update_req, 0);
    check({tag, "_overrun"}, overrun_cnt, 0);
    check({tag, "_state"}, fsm_state, UPD_IDLE);
  endtask

  task automatic check_timing(input string tag);
    check({tag, "_x"}, pix_x, mx);
    check({tag, "_y"}, pix_y, my);
    check({tag, "_hsync"}, vga_hsync, !(mx >= 7 && mx <= 9));
    check({tag, "_vsync"}, vga_vsync, !(my >= 6 && my <= 7));
    check({tag, "_video"}, video_on, (mx < 6 && my < 5));
    check({tag, "_fstart"}, frame_start, (mx == 0 && my == 0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");

    // Release: first edge lands on (1,0); ACK held high during free-run.
    ack   = 1'b1;
    rst_n = 1'b1;
    step();
    check_timing("first_edge");

    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      check_timing("freerun");
    end
    check("freerun_overrun", overrun_cnt, 0);

    // One full frame from (0,0): length, visible, sync totals, held-ACK pulse.
    run_to(0, 0);
    check("measure_start_fs", frame_start, 1);
    cyc = 0; vis = 0; hs_low = 0; vs_low = 0; hi = 0;
    do begin
      if (video_on) vis++;
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (update_req) hi++;
      step();
      cyc++;
    end while (!frame_start && cyc < 300);
    check("frame_len", cyc, FRAME);
    check("visible_cycles", vis, 30);
    check("hsync_low_cycles", hs_low, 27);
    check("vsync_low_cycles", vs_low, 24);
    check("held_ack_req_cycles", hi, 1);

    // ACK 10 clocks after UPDATE_REQ rises.
    ack = 1'b0;
    wait_req_rise("ack10");
    hi = 1;
    repeat (10) begin
      step();
      if (update_req) hi++;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack10_req_cycles", hi, 11);
    check("ack10_req_after", update_req, 0);
    check("ack10_state", fsm_state, UPD_DONE);
    hi = 0;
    for (int g = 0; g < 300 && !(mx == 0 && my == 0); g++) begin
      if (update_req) hi++;
      step();
    end
    check("ack10_no_reopen", hi, 0);
    check("ack10_overrun", overrun_cnt, 0);
    check("ack10_state_idle", fsm_state, UPD_IDLE);

    // Never ACK for 257 frames: saturating overrun count.
    for (int f = 1; f <= 257; f++) begin
      wait_req_rise("noack");
      run_to(0, 0);
      check("noack_overrun", overrun_cnt, (f > 255) ? 255 : f);
      check("noack_state", fsm_state, UPD_IDLE);
    end

    // Asynchronous reset mid-REQ at (5,6), away from any clock edge.
    wait_req_rise("areset");
    run_to(5, 6);
    check("areset_in_req", fsm_state, UPD_REQ);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("areset");
    mx = 0;
    my = 0;
    repeat (2) step();
    check_reset_values("areset_hold");
    rst_n = 1'b1;
    step();
    check_timing("areset_release");

    // ACK only on the frame's last cycle: ACK wins, no overrun.
    wait_req_rise("lastack");
    hi = 0;
    for (int g = 0; g < 300; g++) begin
      if (update_req) hi++;
      if (mx == H_LAST && my == V_LAST) break;
      step();
    end
    check("lastack_req_cycles", hi, 48);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("lastack_overrun", overrun_cnt, 0);
    check("lastack_state", fsm_state, UPD_IDLE);
    check("lastack_req", update_req, 0);
    check("lastack_fstart", frame_start, 1);

    // ACK held constantly high: a one-cycle request per frame.
    ack = 1'b1;
    for (int f = 0; f < 2; f++) begin
      hi = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (update_req) hi++;
        step();
      end
      check("held_ack_pulse", hi, 1);
    end
    check("held_ack_overrun", overrun_cnt, 0);
    ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 The block SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal porch and sync widths in clocks.
REQ-003 The block SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical widths in lines.
REQ-004 The block SHALL have port CLK_25MHZ, input, 1: pixel clock; all state on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port UPDATE_ACK, input, 1: game logic finished its per-frame update.
REQ-007 The block SHALL have port VGA_HSYNC, output, 1: horizontal sync, active low.
REQ-008 The block SHALL have port VGA_VSYNC, output, 1: vertical sync, active low.
REQ-009 The block SHALL have port VIDEO_ON, output, 1: high in the visible area.
REQ-010 The block SHALL have ports PIX_X and PIX_Y, output, 10 each: current horizontal and vertical counters.
REQ-011 The block SHALL have port FRAME_START, output, 1: one-cycle pulse at (0,0).
REQ-012 The block SHALL have port UPDATE_REQ, output, 1: game update window open.
REQ-013 The block SHALL have port OVERRUN_CNT, output, 8: saturating count of missed updates.

Function
REQ-014 Totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
REQ-015 PIX_X SHALL increment each clock and wrap from H_TOTAL-1 to 0.
REQ-016 PIX_Y SHALL increment on each PIX_X wrap and wrap from V_TOTAL-1 to 0.
REQ-017 Every output SHALL be a flop output, and VGA_HSYNC, VGA_VSYNC, VIDEO_ON and FRAME_START SHALL be aligned with the PIX_X/PIX_Y value of the same cycle; decode SHALL use next-state counters.
REQ-018 VIDEO_ON SHALL be 1 iff PIX_X<H_VISIBLE and PIX_Y<V_VISIBLE.
REQ-019 VGA_HSYNC SHALL be 0 iff H_VISIBLE+H_FRONT <= PIX_X < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
REQ-020 VGA_VSYNC SHALL be 0 iff V_VISIBLE+V_FRONT <= PIX_Y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
REQ-021 FRAME_START SHALL be 1 only in the cycle where (PIX_X,PIX_Y)=(0,0).
REQ-022 The update FSM SHALL have three states: IDLE, REQ, DONE.
REQ-023 The FSM SHALL go IDLE->REQ in the cycle where (PIX_X,PIX_Y)=(0,V_VISIBLE), and UPDATE_REQ SHALL be 1 in exactly that cycle and every cycle in REQ.
REQ-024 REQ->DONE SHALL occur on the clock edge where UPDATE_ACK=1, so UPDATE_REQ is 0 from the next cycle.
REQ-025 DONE->IDLE SHALL occur on the edge leaving (H_TOTAL-1,V_TOTAL-1).
REQ-026 If the FSM is still in REQ at (H_TOTAL-1,V_TOTAL-1) with UPDATE_ACK=0, it SHALL go to IDLE and OVERRUN_CNT SHALL increment by 1, saturating at 255.
REQ-027 If UPDATE_ACK=1 in that same last cycle, the ACK SHALL win: no overrun is counted and the FSM goes to IDLE.
REQ-028 UPDATE_ACK SHALL be ignored in IDLE and DONE, and a held ACK SHALL NOT complete the next frame's REQ before the cycle it opens.

Reset
REQ-029 While RESET_N=0: PIX_X=0, PIX_Y=0, VGA_HSYNC=1, VGA_VSYNC=1, VIDEO_ON=0, FRAME_START=0, UPDATE_REQ=0, OVERRUN_CNT=0, FSM=IDLE.
REQ-030 After RESET_N rises, the first clock edge SHALL move the counters to (1,0), so frame 0's (0,0) cycle has FRAME_START=0 and timing stays continuous.
REQ-031 Reset asserted mid-frame or mid-REQ SHALL abort immediately to the reset values; there is no partial-frame recovery.

Structure
REQ-032 The timing parameter defaults, H_TOTAL/V_TOTAL and the FSM state encoding SHALL live in shared package vga_timing_pkg.
REQ-033 One sub-module, vga_axis_counter (counter, wrap, sync and visible decode), SHALL be instantiated twice, once per axis; the FSM SHALL stay in the top module.

Verification
REQ-034 Bench: free-run 2 frames after reset -> VGA_HSYNC low 96 clocks per line starting at PIX_X=656; VGA_VSYNC low for lines 490-491; 525 lines of 800 clocks per frame.
REQ-035 Bench: count VIDEO_ON=1 cycles over one frame -> exactly 307200.
REQ-036 Bench: ACK 10 clocks after UPDATE_REQ rises -> UPDATE_REQ high for exactly 11 cycles; OVERRUN_CNT stays 0.
REQ-037 Bench: never ACK for 257 frames -> OVERRUN_CNT reaches 255 and holds; UPDATE_REQ rises once per frame at (0,480).
REQ-038 Bench: ACK only at (799,524) -> no increment; ACK held constantly high -> UPDATE_REQ is a 1-cycle pulse per frame.
REQ-039 Bench: assert RESET_N=0 at (300,481) while in REQ -> all outputs at reset values asynchronously, before the next clock edge.
